// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the Y86 pipeline: shares one unified memory port
// between fetch reads and memory-stage reads/writes, with the memory stage taking priority.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT = 2,
   parameter int unsigned ADDR_W  = 64
) (
   input  logic              clk,
   input  logic              rst,
   // fetch requester
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_done,
   output logic [63:0]       f_rdata,
   output logic              f_err,
   // memory-stage requester
   input  logic              m_req,
   input  logic              m_we,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [63:0]       m_wdata,
   output logic              m_done,
   output logic [63:0]       m_rdata,
   output logic              m_err,
   // memory port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_rdata,
   input  logic              mem_err,
   // pipeline stall requests
   output logic              f_stall_req,
   output logic              m_stall_req
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_F = 3'd1,
      BUSY_M = 3'd2,
      DONE_F = 3'd3,
      DONE_M = 3'd4
   } state_t;

   state_t            state;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_d;

   logic              mem_en_d;
   logic              mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [63:0]       mem_wdata_d;
   logic              f_done_d;
   logic              m_done_d;
   logic [63:0]       f_rdata_d;
   logic              f_err_d;
   logic [63:0]       m_rdata_d;
   logic              m_err_d;

   // State and latency counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   // Next state and next values of the registered outputs
   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      mem_en_d    = mem_en;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      f_done_d    = 1'b0;
      m_done_d    = 1'b0;
      f_rdata_d   = f_rdata;
      f_err_d     = f_err;
      m_rdata_d   = m_rdata;
      m_err_d     = m_err;

      case (state)
         IDLE: begin
            // Memory stage holds the older instruction, so it wins a tie
            if (m_req) begin
               state_d     = BUSY_M;
               cnt_d       = CNT_LOAD;
               mem_en_d    = 1'b1;
               mem_we_d    = m_we;
               mem_addr_d  = m_addr;
               mem_wdata_d = m_wdata;
            end else if (f_req) begin
               state_d     = BUSY_F;
               cnt_d       = CNT_LOAD;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = f_addr;
               mem_wdata_d = '0;
            end
         end

         BUSY_F: begin
            if (cnt == '0) begin
               state_d   = DONE_F;
               mem_en_d  = 1'b0;
               mem_we_d  = 1'b0;
               f_done_d  = 1'b1;
               f_rdata_d = mem_rdata;
               f_err_d   = mem_err;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end

         BUSY_M: begin
            if (cnt == '0) begin
               state_d  = DONE_M;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
               m_done_d = 1'b1;
               m_err_d  = mem_err;
               // a write reports status only; read data is kept from the last read
               if (!mem_we) begin
                  m_rdata_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end

         DONE_F, DONE_M: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered outputs; async reset drops the memory port in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f_done    <= 1'b0;
         m_done    <= 1'b0;
         f_rdata   <= '0;
         f_err     <= 1'b0;
         m_rdata   <= '0;
         m_err     <= 1'b0;
      end else begin
         mem_en    <= mem_en_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         f_done    <= f_done_d;
         m_done    <= m_done_d;
         f_rdata   <= f_rdata_d;
         f_err     <= f_err_d;
         m_rdata   <= m_rdata_d;
         m_err     <= m_err_d;
      end
   end

   assign f_stall_req = f_req & ~f_done;
   assign m_stall_req = m_req & ~m_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three builds (MEM_LAT 2, 1, 15) checked every cycle against a
// transaction-timeline model, plus directed scenarios with hand-computed expectations.
module tb_mem_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 64;

   logic clk = 1'b0;
   logic rst;

   logic          f_req       [N];
   logic [AW-1:0] f_addr      [N];
   logic          f_done      [N];
   logic [63:0]   f_rdata     [N];
   logic          f_err       [N];
   logic          m_req       [N];
   logic          m_we        [N];
   logic [AW-1:0] m_addr      [N];
   logic [63:0]   m_wdata     [N];
   logic          m_done      [N];
   logic [63:0]   m_rdata     [N];
   logic          m_err       [N];
   logic          mem_en      [N];
   logic          mem_we      [N];
   logic [AW-1:0] mem_addr    [N];
   logic [63:0]   mem_wdata   [N];
   logic          f_stall_req [N];
   logic          m_stall_req [N];
   logic [63:0]   mem_rdata;
   logic          mem_err;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int unsigned LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;
      mem_port_arbiter #(.MEM_LAT(LAT), .ADDR_W(AW)) dut (
         .clk(clk), .rst(rst),
         .f_req(f_req[g]), .f_addr(f_addr[g]), .f_done(f_done[g]),
         .f_rdata(f_rdata[g]), .f_err(f_err[g]),
         .m_req(m_req[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
         .m_done(m_done[g]), .m_rdata(m_rdata[g]), .m_err(m_err[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata), .mem_err(mem_err),
         .f_stall_req(f_stall_req[g]), .m_stall_req(m_stall_req[g])
      );
   end

   int n_cmp = 0;
   int n_mis = 0;
   longint cyc = 0;

   function automatic void cmp1(input string nm, input int i, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s inst%0d cyc=%0d got=%b want=%b", nm, i, cyc, act, exp);
      end
   endfunction

   function automatic void cmp64(input string nm, input int i, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, i, cyc, act, exp);
      end
   endfunction

   // Model: an accepted access at cycle a is busy in a+1..a+L, done at a+L+1, idle after.
   int          lat    [N] = '{2, 1, 15};
   int          owner  [N];        // 0 none, 1 fetch, 2 memory stage
   longint      acc    [N];
   logic        lwe    [N];
   logic [63:0] laddr  [N];
   logic [63:0] lwdata [N];
   logic [63:0] e_frd  [N];
   logic [63:0] e_mrd  [N];
   logic        e_ferr [N];
   logic        e_merr [N];
   logic        e_fdone[N];
   logic        e_mdone[N];

   longint d;
   logic   c_busy, c_done, c_we, c_idle;

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (rst) begin
            owner[i] = 0;
            e_frd[i] = '0; e_mrd[i] = '0; e_ferr[i] = 1'b0; e_merr[i] = 1'b0;
         end
         d      = cyc - acc[i];
         c_busy = (owner[i] != 0) && (d >= 1) && (d <= longint'(lat[i]));
         c_done = (owner[i] != 0) && (d == longint'(lat[i]) + 1);
         c_we   = c_busy && (owner[i] == 2) && lwe[i];
         e_fdone[i] = c_done && (owner[i] == 1);
         e_mdone[i] = c_done && (owner[i] == 2);

         cmp1("f_done", i, f_done[i], e_fdone[i]);
         cmp1("m_done", i, m_done[i], e_mdone[i]);
         cmp1("mem_en", i, mem_en[i], c_busy);
         cmp1("mem_we", i, mem_we[i], c_we);
         cmp64("f_rdata", i, f_rdata[i], e_frd[i]);
         cmp1("f_err", i, f_err[i], e_ferr[i]);
         cmp64("m_rdata", i, m_rdata[i], e_mrd[i]);
         cmp1("m_err", i, m_err[i], e_merr[i]);
         cmp1("f_stall_req", i, f_stall_req[i], f_req[i] & ~e_fdone[i]);
         cmp1("m_stall_req", i, m_stall_req[i], m_req[i] & ~e_mdone[i]);
         if (c_busy) cmp64("mem_addr", i, mem_addr[i], laddr[i]);
         if (c_we)   cmp64("mem_wdata", i, mem_wdata[i], lwdata[i]);

         if (!rst) begin
            if (c_busy && d == longint'(lat[i])) begin
               if (owner[i] == 1) begin
                  e_frd[i] = mem_rdata; e_ferr[i] = mem_err;
               end else begin
                  if (!lwe[i]) e_mrd[i] = mem_rdata;
                  e_merr[i] = mem_err;
               end
            end
            c_idle = (owner[i] == 0);
            if (c_done) owner[i] = 0;
            if (c_idle) begin
               if (m_req[i]) begin
                  owner[i] = 2; acc[i] = cyc; lwe[i] = m_we[i];
                  laddr[i] = m_addr[i]; lwdata[i] = m_wdata[i];
               end else if (f_req[i]) begin
                  owner[i] = 1; acc[i] = cyc; laddr[i] = f_addr[i];
               end
            end
         end
      end
      cyc++;
   end

   int   per   [N] = '{4, 3, 17};
   int   blen  [N] = '{2, 1, 15};
   int   ndn   [N] = '{17, 23, 4};
   int   last_done [N];
   int   run   [N];
   int   ndone [N];
   logic f_act [N];
   logic m_act [N];

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin
         f_req[i] = 1'b0; m_req[i] = 1'b0; m_we[i] = 1'b0;
         f_act[i] = 1'b0; m_act[i] = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      mem_rdata = '0; mem_err = 1'b0;
      for (int i = 0; i < N; i++) begin
         f_addr[i] = '0; m_addr[i] = '0; m_wdata[i] = '0;
      end
      clear_reqs();
      repeat (3) @(posedge clk);
      @(negedge clk); #1 rst = 1'b0;

      // A: single fetch, MEM_LAT=2
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         case (k)
            0: begin f_req[0] = 1'b1; f_addr[0] = 64'h100; end
            1: mem_rdata = 64'h1111_2222_3333_4444;
            2: mem_rdata = 64'hABCD_0000_1234_5678;
            4: f_req[0] = 1'b0;
            default: ;
         endcase
         @(negedge clk);
         cmp1("a_mem_en", 0, mem_en[0], k inside {1, 2});
         if (k inside {1, 2}) cmp64("a_mem_addr", 0, mem_addr[0], 64'h100);
         cmp1("a_f_done", 0, f_done[0], k == 3);
         cmp1("a_f_stall", 0, f_stall_req[0], k <= 2);
         if (k == 3) cmp64("a_f_rdata", 0, f_rdata[0], 64'hABCD_0000_1234_5678);
      end

      // B: simultaneous requests, memory-stage write goes first
      for (int k = 0; k < 9; k++) begin
         @(posedge clk); #1;
         mem_rdata = 64'hC0DE_0000_0000_0000 | 64'(k);
         case (k)
            0: begin
               f_req[0] = 1'b1; f_addr[0] = 64'h180;
               m_req[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 64'h200; m_wdata[0] = 64'hDEADBEEF;
            end
            4: begin m_req[0] = 1'b0; m_we[0] = 1'b0; end
            8: f_req[0] = 1'b0;
            default: ;
         endcase
         @(negedge clk);
         cmp1("b_m_done", 0, m_done[0], k == 3);
         cmp1("b_f_done", 0, f_done[0], k == 7);
         cmp1("b_f_stall", 0, f_stall_req[0], k <= 6);
         cmp1("b_m_stall", 0, m_stall_req[0], k <= 2);
         cmp1("b_mem_en", 0, mem_en[0], k inside {1, 2, 5, 6});
         cmp1("b_mem_we", 0, mem_we[0], k inside {1, 2});
         if (k inside {1, 2}) begin
            cmp64("b_mem_addr_m", 0, mem_addr[0], 64'h200);
            cmp64("b_mem_wdata", 0, mem_wdata[0], 64'hDEADBEEF);
         end
         if (k inside {5, 6}) cmp64("b_mem_addr_f", 0, mem_addr[0], 64'h180);
         if (k == 3) cmp64("b_m_rdata_wr", 0, m_rdata[0], 64'h0);
         if (k == 7) cmp64("b_f_rdata", 0, f_rdata[0], 64'hC0DE_0000_0000_0006);
      end

      // C: error in final cycle, address change ignored, early error ignored
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         mem_rdata = 64'hC0DE_0000_0000_0000 | 64'(k);
         mem_err   = (k == 2) || (k == 6);
         case (k)
            0: begin m_req[0] = 1'b1; m_we[0] = 1'b0; m_addr[0] = 64'h300; end
            1: m_addr[0] = 64'h308;
            4: m_req[0] = 1'b0;
            5: begin m_req[0] = 1'b1; m_addr[0] = 64'h310; end
            9: m_req[0] = 1'b0;
            default: ;
         endcase
         @(negedge clk);
         if (k inside {1, 2}) cmp64("c_mem_addr_hold", 0, mem_addr[0], 64'h300);
         if (k inside {6, 7}) cmp64("c_mem_addr2", 0, mem_addr[0], 64'h310);
         cmp1("c_m_done", 0, m_done[0], k == 3 || k == 8);
         cmp1("c_m_err", 0, m_err[0], k >= 3 && k <= 7);
         if (k == 3) cmp64("c_m_rdata1", 0, m_rdata[0], 64'hC0DE_0000_0000_0002);
         if (k == 8) cmp64("c_m_rdata2", 0, m_rdata[0], 64'hC0DE_0000_0000_0007);
      end
      mem_err = 1'b0;

      // D: reset in the middle of a memory-stage write
      @(posedge clk); #1;
      m_req[0] = 1'b1; m_we[0] = 1'b1; m_addr[0] = 64'h400; m_wdata[0] = 64'h1234;
      @(posedge clk); #3;
      rst = 1'b1;
      clear_reqs();
      #1;
      cmp1("d_mem_en", 0, mem_en[0], 1'b0);
      cmp1("d_mem_we", 0, mem_we[0], 1'b0);
      cmp1("d_m_done", 0, m_done[0], 1'b0);
      cmp64("d_m_rdata", 0, m_rdata[0], 64'h0);
      cmp1("d_m_err", 0, m_err[0], 1'b0);
      cmp64("d_f_rdata", 0, f_rdata[0], 64'h0);
      cmp64("d_mem_wdata", 0, mem_wdata[0], 64'h0);
      @(posedge clk);
      @(negedge clk); #1 rst = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(posedge clk); #1;
         mem_rdata = 64'h0D00_0000_0000_0000 | 64'(j);
         if (j == 0) begin f_req[0] = 1'b1; f_addr[0] = 64'h500; end
         if (j == 4) f_req[0] = 1'b0;
         @(negedge clk);
         cmp1("d_f_done", 0, f_done[0], j == 3);
         cmp1("d_no_stale_m_done", 0, m_done[0], 1'b0);
         if (j == 3) cmp64("d_f_rdata2", 0, f_rdata[0], 64'h0D00_0000_0000_0002);
      end

      // E: fetch held high on every build; period and busy length
      for (int i = 0; i < N; i++) begin
         last_done[i] = -1; run[i] = 0; ndone[i] = 0;
      end
      for (int c = 0; c < 70; c++) begin
         @(posedge clk); #1;
         mem_rdata = {$urandom, $urandom};
         if (c == 0) for (int i = 0; i < N; i++) begin
            f_req[i] = 1'b1; f_addr[i] = 64'h600 + 64'(i * 8);
         end
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (f_done[i]) begin
               if (last_done[i] >= 0) cmp64("e_period", i, 64'(c - last_done[i]), 64'(per[i]));
               last_done[i] = c;
               ndone[i]++;
            end
            if (mem_en[i]) run[i]++;
            else if (run[i] > 0) begin
               cmp64("e_busy_len", i, 64'(run[i]), 64'(blen[i]));
               run[i] = 0;
            end
         end
      end
      for (int i = 0; i < N; i++) cmp64("e_ndone", i, 64'(ndone[i]), 64'(ndn[i]));
      @(posedge clk); #1;
      clear_reqs();
      repeat (20) @(posedge clk);
      #1;

      // R: randomized traffic with one mid-run reset
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         mem_rdata = {$urandom, $urandom};
         mem_err   = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) begin
            if (e_fdone[i]) f_act[i] = 1'b0;
            if (!f_act[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  f_act[i] = 1'b1; f_req[i] = 1'b1; f_addr[i] = {$urandom, $urandom};
               end else f_req[i] = 1'b0;
            end else if (owner[i] == 1 && $urandom_range(0, 1) == 1) begin
               f_addr[i] = {$urandom, $urandom};
            end
            if (e_mdone[i]) m_act[i] = 1'b0;
            if (!m_act[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  m_act[i] = 1'b1; m_req[i] = 1'b1; m_we[i] = 1'($urandom_range(0, 1));
                  m_addr[i] = {$urandom, $urandom}; m_wdata[i] = {$urandom, $urandom};
               end else m_req[i] = 1'b0;
            end else if (owner[i] == 2 && $urandom_range(0, 1) == 1) begin
               m_we[i] = ~m_we[i];
               m_addr[i] = {$urandom, $urandom}; m_wdata[i] = {$urandom, $urandom};
            end
         end
         if (c == 2000) begin
            #2 rst = 1'b1;
            clear_reqs();
            @(posedge clk);
            @(negedge clk); #1 rst = 1'b0;
         end
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbiter and sequencer for the single-ported unified instruction/data memory of the pipelined Y86 core.
- Shares the port between the fetch stage (64-bit instruction-word reads) and the memory stage (64-bit reads/writes).
- Sequences each multi-cycle access and returns data and error status.
- Emits per-stage stall requests that the pipeline control logic ORs into F_stall and M-stage hold.

Parameters:
- MEM_LAT, 2, memory access latency in cycles; legal range 1..15.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- f_req  in  1  fetch read request; level, held until f_done
- f_addr  in  ADDR_W  fetch address
- f_done  out  1  one-cycle pulse: fetch access complete, f_rdata/f_err valid
- f_rdata  out  64  fetch read data
- f_err  out  1  fetch access faulted (maps to ADR stat)
- m_req  in  1  memory-stage request; level, held until m_done
- m_we  in  1  1 = write, 0 = read
- m_addr  in  ADDR_W  memory-stage address
- m_wdata  in  64  write data
- m_done  out  1  one-cycle pulse: memory-stage access complete
- m_rdata  out  64  memory-stage read data
- m_err  out  1  memory-stage access faulted
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data
- mem_err  in  1  memory address fault
- f_stall_req  out  1  fetch must stall this cycle
- m_stall_req  out  1  memory stage must stall this cycle

Behaviour:
- States: IDLE, BUSY_F, BUSY_M, DONE_F, DONE_M. State and 4-bit counter are registered.
- Reset (async, immediate): state IDLE; all outputs 0, including data and err registers. An in-flight access is abandoned and mem_en drops in the same cycle rst rises.
- IDLE:
  - m_req=1 -> BUSY_M; latch m_addr, m_we, m_wdata; cnt <= MEM_LAT-1.
  - else f_req=1 -> BUSY_F; latch f_addr; cnt <= MEM_LAT-1.
  - Both requests in the same cycle: M wins (older instruction). F stays pending.
- BUSY_x:
  - mem_en=1; mem_addr/mem_wdata/mem_we driven from latched values, stable for the whole state.
  - mem_we=1 only in BUSY_M with a latched write.
  - cnt decrements each cycle.
  - When cnt==0: sample mem_rdata and mem_err into x_rdata/x_err, then -> DONE_x.
  - A BUSY state lasts exactly MEM_LAT cycles.
- DONE_x: x_done=1 for exactly one cycle; mem_en=0; -> IDLE unconditionally.
  - The requester deasserts x_req in this cycle. A req still high in the next IDLE cycle is a new request.
- Completion timing: request accepted at edge E gives x_done high in cycle E+MEM_LAT+1. Back-to-back throughput is one access per MEM_LAT+2 cycles.
- x_rdata/x_err hold their value until the next completion of the same requester.
  - Write completions leave m_rdata unchanged.
  - A write completion does update m_err.
- Requester inputs changing after acceptance are ignored until DONE.
- Stall requests (combinational):
  - f_stall_req = f_req & ~f_done.
  - m_stall_req = m_req & ~m_done.
- mem_err is sampled only in the final BUSY cycle and ignored in all other cycles.

Test Plan:
- MEM_LAT=2: f_req=1, f_addr=0x100 from IDLE -> mem_en high 2 cycles with mem_addr=0x100; f_done pulses in cycle 3 with f_rdata=mem_rdata sampled in cycle 2; f_stall_req=1 in cycles 0-2, 0 in cycle 3.
- f_req and m_req both rise in cycle 0 (m_we=1, m_addr=0x200, m_wdata=0xDEADBEEF) -> mem_we=1 with 0x200/0xDEADBEEF first; m_done in cycle 3; fetch accepted in cycle 4, f_done in cycle 7; f_stall_req=1 in cycles 0-6.
- Read with mem_err=1 in the final BUSY cycle -> m_err=1 with m_done; next error-free read clears m_err; mem_err pulsed in a non-final BUSY cycle -> no error reported.
- Assert rst in the middle of BUSY_M -> mem_en, mem_we, m_done and all data/err outputs 0 immediately; after release, a new f_req completes normally with no stale m_done.
- MEM_LAT=1 and MEM_LAT=15 builds: BUSY lasts exactly 1 and 15 cycles respectively; back-to-back requests held high complete every 3 and 17 cycles.
- m_addr changed from 0x300 to 0x308 after acceptance -> mem_addr stays 0x300 through the whole access.
